// File: rtl/in_keys_pio.sv
// ----------------------------------------------------------------------------
// in_keys_pio
//
// Avalon-MM slave input port for vending-machine push-buttons and coin
// switches. Raw pins are normalised (1 = pressed), passed through a two-flop
// synchronizer and debounced per channel. The clean pressed state is readable
// by the CPU, presses are latched in a sticky edge-capture register, and a
// maskable level interrupt is raised while any masked-in capture bit is set.
//
// Ports:
//   clk         system clock
//   reset_n     asynchronous, active-low reset
//   address     register select (0 data, 1 reserved, 2 irq_mask, 3 edge_capture)
//   chipselect  slave select
//   write_n     active-low write strobe
//   writedata   write data (WIDTH bits)
//   readdata    registered read data, 1-cycle latency
//   in_port     raw asynchronous pins
//   irq         interrupt request, active high
// ----------------------------------------------------------------------------
module in_keys_pio #(
    parameter int WIDTH      = 4,
    parameter int DEB_CYCLES = 50000,
    parameter int ACTIVE_LOW = 1,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [WIDTH-1:0] writedata,
    output logic [WIDTH-1:0] readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

    logic [WIDTH-1:0] pin_norm;
    logic [WIDTH-1:0] sync1_reg;
    logic [WIDTH-1:0] sync2_reg;
    logic [WIDTH-1:0] d_reg;
    logic [WIDTH-1:0] d_next;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] edge_reg;
    logic [WIDTH-1:0] edge_next;
    logic [WIDTH-1:0] mask_reg;
    logic [WIDTH-1:0] readdata_reg;
    logic [WIDTH-1:0] read_mux;
    logic [WIDTH-1:0] clear_bits;
    logic             wr_en;
    logic             rd_en;

    // After normalisation a 1 always means "pressed"; the idle value is 0,
    // which matches the synchronizer reset value so reset never looks like
    // a press or a release.
    assign pin_norm = (ACTIVE_LOW != 0) ? ~in_port : in_port;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
        end else begin
            sync1_reg <= pin_norm;
            sync2_reg <= sync1_reg;
        end
    end

    // Per-channel debounce: the counter runs only while the synchronized
    // sample disagrees with the accepted state. Any agreeing sample restarts
    // it, so only an uninterrupted run of DEB_CYCLES differing samples is
    // accepted. The counter never passes CNT_MAX, so it cannot wrap.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_deb
            logic [CNT_W-1:0] cnt_reg;
            logic             differ;
            logic             at_max;

            assign differ = sync2_reg[gi] ^ d_reg[gi];
            assign at_max = (cnt_reg == CNT_MAX);

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    cnt_reg <= '0;
                end else if (!differ || at_max) begin
                    cnt_reg <= '0;
                end else begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end

            assign d_next[gi] = (differ && at_max) ? sync2_reg[gi] : d_reg[gi];
            // A press is the accepted state going 0 -> 1 on this edge.
            assign rise[gi]   = differ && at_max && sync2_reg[gi];
        end
    endgenerate

    assign wr_en = chipselect & ~write_n;
    assign rd_en = chipselect & write_n;

    // W1C clear is applied before OR-ing in new presses, so a press landing
    // on the same edge as its clear still leaves the bit set.
    assign clear_bits = (wr_en && address == 2'd3) ? writedata : '0;
    assign edge_next  = (edge_reg & ~clear_bits) | rise;

    always_comb begin
        read_mux = '0;
        case (address)
            2'd0:    read_mux = d_reg;
            2'd2:    read_mux = mask_reg;
            2'd3:    read_mux = edge_reg;
            default: read_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            d_reg        <= '0;
            edge_reg     <= '0;
            mask_reg     <= '0;
            readdata_reg <= '0;
        end else begin
            d_reg    <= d_next;
            edge_reg <= edge_next;
            if (wr_en && address == 2'd2) begin
                mask_reg <= writedata;
            end
            // The mux sees pre-edge register values, so a read racing a
            // capture returns the value from before the capture.
            if (rd_en) begin
                readdata_reg <= read_mux;
            end
        end
    end

    assign readdata = readdata_reg;
    assign irq      = |(edge_reg & mask_reg);

endmodule

// File: tb/tb_in_keys_pio.sv
// ----------------------------------------------------------------------------
// tb_in_keys_pio
//
// Self-checking bench for in_keys_pio. A behavioural model keeps the history
// of normalised pin samples taken at each clock edge; a channel's accepted
// state flips when the DEB most recent samples that have reached the
// synchronizer output all hold the opposite value. Directed scenarios cover
// reset, clean press, bounce, W1C/mask, set/clear collision and reset in the
// middle of a debounce; a randomized phase follows.
// ----------------------------------------------------------------------------
module tb_in_keys_pio;

    localparam int WIDTH = 4;
    localparam int DEB   = 4;
    localparam int AL    = 1;
    localparam int CNT_W = 16;

    logic             clk        = 1'b0;
    logic             reset_n    = 1'b0;
    logic [1:0]       address    = '0;
    logic             chipselect = 1'b0;
    logic             write_n    = 1'b1;
    logic [WIDTH-1:0] writedata  = '0;
    logic [WIDTH-1:0] in_port    = '1;
    logic [WIDTH-1:0] readdata;
    logic             irq;

    always #5 clk = ~clk;

    in_keys_pio #(
        .WIDTH     (WIDTH),
        .DEB_CYCLES(DEB),
        .ACTIVE_LOW(AL),
        .CNT_W     (CNT_W)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata),
        .in_port   (in_port),
        .irq       (irq)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic [WIDTH-1:0] m_d    = '0;
    logic [WIDTH-1:0] m_edge = '0;
    logic [WIDTH-1:0] m_mask = '0;
    logic [WIDTH-1:0] m_rd   = '0;
    // hist[0] is the sample taken at the current edge, hist[k] k edges ago.
    logic [WIDTH-1:0] hist [DEB+2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_d    = '0;
        m_edge = '0;
        m_mask = '0;
        m_rd   = '0;
        for (int j = 0; j < DEB + 2; j++) hist[j] = '0;
    endtask

    // Advance the model by one clock edge using the inputs present at it.
    task automatic model_edge();
        logic [WIDTH-1:0] norm;
        logic [WIDTH-1:0] rise;
        logic [WIDTH-1:0] clr;
        logic             all1;
        logic             all0;
        norm = (AL != 0) ? ~in_port : in_port;
        if (chipselect && write_n) begin
            case (address)
                2'd0:    m_rd = m_d;
                2'd2:    m_rd = m_mask;
                2'd3:    m_rd = m_edge;
                default: m_rd = '0;
            endcase
        end
        for (int j = DEB + 1; j > 0; j--) hist[j] = hist[j-1];
        hist[0] = norm;
        rise = '0;
        for (int i = 0; i < WIDTH; i++) begin
            all1 = 1'b1;
            all0 = 1'b1;
            // Samples from 2..DEB+1 edges ago are what the synchronizer
            // output has shown over the last DEB edges.
            for (int j = 2; j <= DEB + 1; j++) begin
                if (hist[j][i] !== 1'b1) all1 = 1'b0;
                if (hist[j][i] !== 1'b0) all0 = 1'b0;
            end
            if (!m_d[i] && all1) begin
                m_d[i]  = 1'b1;
                rise[i] = 1'b1;
            end else if (m_d[i] && all0) begin
                m_d[i] = 1'b0;
            end
        end
        clr = (chipselect && !write_n && address == 2'd3) ? writedata : '0;
        if (chipselect && !write_n && address == 2'd2) m_mask = writedata;
        m_edge = (m_edge & ~clr) | rise;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("readdata", 32'(readdata), 32'(m_rd));
        chk("irq", 32'(irq), 32'(|(m_edge & m_mask)));
    endtask

    task automatic bus_idle(input int n);
        chipselect = 1'b0;
        write_n    = 1'b1;
        repeat (n) step();
    endtask

    task automatic bus_wr(input logic [1:0] a, input logic [WIDTH-1:0] d);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
        step();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic bus_rd(input logic [1:0] a, output logic [WIDTH-1:0] v);
        chipselect = 1'b1;
        write_n    = 1'b1;
        address    = a;
        step();
        v          = readdata;
        chipselect = 1'b0;
    endtask

    // Called at a falling edge; holds reset across one rising edge.
    task automatic do_reset();
        reset_n = 1'b0;
        model_clear();
        #1;
        chk("rst_async_rd", 32'(readdata), 32'h0);
        chk("rst_async_irq", 32'(irq), 32'h0);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        logic [WIDTH-1:0] v;
        int               idx;
        int               rate;

        model_clear();
        in_port = '1;
        @(negedge clk);
        do_reset();

        // Reset state
        bus_idle(3);
        bus_rd(2'd0, v); chk("rst_data", 32'(v), 32'h0);
        bus_rd(2'd2, v); chk("rst_mask", 32'(v), 32'h0);
        bus_rd(2'd3, v); chk("rst_edge", 32'(v), 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);

        // Clean press on channel 0 with continuous data reads
        bus_wr(2'd2, 4'h1);
        in_port[0] = 1'b0;
        chipselect = 1'b1;
        write_n    = 1'b1;
        address    = 2'd0;
        repeat (5) step();
        chk("press_irq_pre", 32'(irq), 32'h0);
        step();
        chk("press_irq", 32'(irq), 32'h1);
        step();
        chk("press_data", 32'(readdata), 32'h1);
        bus_rd(2'd3, v); chk("press_edge", 32'(v), 32'h1);

        // Bounce on channel 1: 3 low, 1 high, 3 low, then released
        in_port[1] = 1'b0; bus_idle(3);
        in_port[1] = 1'b1; bus_idle(1);
        in_port[1] = 1'b0; bus_idle(3);
        in_port[1] = 1'b1; bus_idle(8);
        bus_rd(2'd0, v); chk("bounce_data", 32'(v), 32'h1);
        bus_rd(2'd3, v); chk("bounce_edge", 32'(v), 32'h1);

        // W1C and mask
        in_port[2] = 1'b0;
        bus_idle(8);
        bus_rd(2'd3, v); chk("w1c_before", 32'(v), 32'h5);
        bus_wr(2'd3, 4'h1);
        bus_rd(2'd3, v); chk("w1c_after", 32'(v), 32'h4);
        chk("mask_irq_off", 32'(irq), 32'h0);
        bus_wr(2'd2, 4'h4);
        chk("mask_irq_on", 32'(irq), 32'h1);
        bus_rd(2'd3, v); chk("mask_keeps_edge", 32'(v), 32'h4);

        // Set/clear collision on channel 1; bit 2 clears normally
        in_port[1] = 1'b0;
        bus_idle(5);
        bus_wr(2'd3, 4'h6);
        bus_rd(2'd3, v); chk("collide_edge", 32'(v), 32'h2);
        bus_rd(2'd0, v); chk("collide_data", 32'(v), 32'h7);

        // Reset in the middle of a debounce on channel 3
        in_port = '1;
        bus_idle(8);
        bus_wr(2'd3, 4'hF);
        in_port[3] = 1'b0;
        bus_idle(4);
        do_reset();
        bus_rd(2'd0, v); chk("rstmid_data0", 32'(v), 32'h0);
        bus_idle(4);
        bus_rd(2'd0, v); chk("rstmid_early", 32'(v), 32'h0);
        bus_rd(2'd0, v); chk("rstmid_data", 32'(v), 32'h8);
        bus_rd(2'd3, v); chk("rstmid_edge", 32'(v), 32'h8);

        // Randomized phase: sparse then dense pin toggling, random bus ops
        for (int c = 0; c < 3000; c++) begin
            rate = (c < 1500) ? 11 : 2;
            if ($urandom_range(0, rate) == 0) begin
                idx = int'($urandom_range(0, WIDTH - 1));
                in_port[idx] = ~in_port[idx];
            end
            if ($urandom_range(0, 599) == 0) begin
                do_reset();
            end else begin
                chipselect = 1'($urandom_range(0, 1));
                write_n    = 1'($urandom_range(0, 1));
                address    = 2'($urandom_range(0, 3));
                writedata  = WIDTH'($urandom);
                step();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
